// File: rtl/glyph_blitter.sv
// Glyph blitter: expands one 8x8 font glyph into a stream of 64 pixels,
// fetching each glyph line from an external combinational font lookup.
module glyph_blitter #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_ascii,
  input  logic [6:0] req_col,
  input  logic [5:0] req_row,
  output logic [7:0] font_ascii,
  output logic [3:0] font_line,
  input  logic [7:0] font_row,
  output logic       px_valid,
  input  logic       px_ready,
  output logic [9:0] px_x,
  output logic [8:0] px_y,
  output logic       px_on,
  output logic       busy,
  output logic       done,
  output logic       done_err
);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT} state_t;

  state_t     state;
  logic [7:0] code_q;
  logic [6:0] col_q;
  logic [5:0] row_q;
  logic [2:0] line_q;
  logic [2:0] bit_q;
  logic [7:0] shreg;
  logic       req_oob;
  logic       px_fire;

  assign req_oob = (32'(req_col) >= COLS) || (32'(req_row) >= ROWS);
  assign px_fire = (state == SHIFT) && px_ready;

  // Outputs are plain decodes of registers, so they hold still across any stall.
  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign px_valid   = (state == SHIFT);
  assign px_on      = shreg[7];
  assign px_x       = {col_q, bit_q};
  assign px_y       = {row_q, line_q};
  assign font_ascii = (state == FETCH) ? code_q : 8'h00;
  assign font_line  = (state == FETCH) ? {1'b0, line_q} : 4'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      code_q   <= 8'h00;
      col_q    <= 7'd0;
      row_q    <= 6'd0;
      line_q   <= 3'd0;
      bit_q    <= 3'd0;
      shreg    <= 8'h00;
      done     <= 1'b0;
      done_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples
      // pre-edge values; blocking would make order of statements matter.
      done     <= 1'b0;
      done_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            code_q <= req_ascii[7] ? 8'h3F : req_ascii;
            col_q  <= req_col;
            row_q  <= req_row;
            line_q <= 3'd0;
            bit_q  <= 3'd0;
            if (req_oob) begin
              done     <= 1'b1;
              done_err <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          shreg <= font_row;
          bit_q <= 3'd0;
          state <= SHIFT;
        end
        SHIFT: begin
          if (px_fire) begin
            shreg <= {shreg[6:0], 1'b0};
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              if (line_q == 3'd7) begin
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                line_q <= line_q + 3'd1;
                state  <= FETCH;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_glyph_blitter.sv
// Directed bench for glyph_blitter: a small font model supplies glyph lines and
// every pixel, fetch, timing and reset value is compared against it.
module tb_glyph_blitter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_ascii;
  logic [6:0] req_col;
  logic [5:0] req_row;
  logic [7:0] font_ascii;
  logic [3:0] font_line;
  logic [7:0] font_row;
  logic       px_valid;
  logic       px_ready;
  logic [9:0] px_x;
  logic [8:0] px_y;
  logic       px_on;
  logic       busy;
  logic       done;
  logic       done_err;

  int n_checks = 0;
  int n_fail   = 0;

  glyph_blitter #(.COLS(80), .ROWS(60)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ascii(req_ascii), .req_col(req_col), .req_row(req_row),
    .font_ascii(font_ascii), .font_line(font_line), .font_row(font_row),
    .px_valid(px_valid), .px_ready(px_ready),
    .px_x(px_x), .px_y(px_y), .px_on(px_on),
    .busy(busy), .done(done), .done_err(done_err)
  );

  initial forever #5 clk = ~clk;

  // External font: 'A' is the classic 8x8 bitmap, 8'h7F is a solid block.
  function automatic logic [7:0] font_fn(input logic [7:0] a, input logic [3:0] l);
    logic [7:0] glyph_a [8];
    glyph_a = '{8'h30, 8'h78, 8'hCC, 8'hCC, 8'hFC, 8'hCC, 8'hCC, 8'h00};
    if (a == 8'h41)      return glyph_a[l[2:0]];
    else if (a == 8'h7F) return 8'hFF;
    else                 return a ^ {l[2:0], l[2:0], 2'b01};
  endfunction

  always_comb font_row = font_fn(font_ascii, font_line);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of cycle 1.
  task automatic send_req(input logic [7:0] a, input logic [6:0] c, input logic [5:0] r);
    req_valid = 1'b1;
    req_ascii = a;
    req_col   = c;
    req_row   = r;
    check("req_ready_idle", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Walks one glyph from its first FETCH (cycle 1) through the done cycle.
  task automatic collect(input logic [7:0] code, input logic [6:0] col, input logic [5:0] row,
                         input bit stall);
    int p = 0;
    int cyc = 1;
    int last_hs = 0;
    bit was_stalled = 1'b0;
    logic [7:0] bits;
    forever begin
      if (cyc > 1000) begin
        check("glyph_timeout", cyc, 0);
        break;
      end
      if (busy !== 1'b1) begin
        check("done_pulse", done, 1);
        check("done_err_clear", done_err, 0);
        check("pixel_count", p, 64);
        check("done_after_last_hs", cyc, last_hs + 1);
        if (!stall) check("done_cycle", cyc, 73);
        break;
      end else if (px_valid !== 1'b1) begin
        if (was_stalled) check("stall_drop_valid", px_valid, 1);
        check("fetch_ascii", font_ascii, code);
        check("fetch_line", font_line, p / 8);
        check("busy_no_done", done, 0);
        if (!stall) check("fetch_cycle", cyc, 1 + 9 * (p / 8));
        was_stalled = 1'b0;
      end else begin
        if (p >= 64) begin
          check("extra_pixel", p, 63);
          break;
        end
        bits = font_fn(code, 4'(p / 8));
        check("px_x", px_x, col * 8 + p % 8);
        check("px_y", px_y, row * 8 + p / 8);
        check("px_on", px_on, bits[7 - p % 8]);
        px_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (px_ready) begin
          p++;
          last_hs = cyc;
        end
        was_stalled = !px_ready;
      end
      @(negedge clk);
      cyc++;
    end
    px_ready = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_px_valid"}, px_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_done_err"}, done_err, 0);
    check({tag, "_px_x"}, px_x, 0);
    check({tag, "_px_y"}, px_y, 0);
    check({tag, "_px_on"}, px_on, 0);
    check({tag, "_font_ascii"}, font_ascii, 0);
    check({tag, "_font_line"}, font_line, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_ascii = 8'h00;
    req_col   = 7'd0;
    req_row   = 6'd0;
    px_ready  = 1'b1;

    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 'A' at the origin, sink always ready; then done is a single pulse.
    send_req(8'h41, 7'd0, 6'd0);
    collect(8'h41, 7'd0, 6'd0, 1'b0);
    @(negedge clk);
    check("done_one_cycle", done, 0);

    // Bottom-right cell with the solid glyph: x 632..639, y 472..479, all on.
    send_req(8'h7F, 7'd79, 6'd59);
    collect(8'h7F, 7'd79, 6'd59, 1'b0);
    @(negedge clk);

    // Out-of-range column, then out-of-range row.
    send_req(8'h41, 7'd80, 6'd0);
    check("oob_col_done", done, 1);
    check("oob_col_err", done_err, 1);
    check("oob_col_no_px", px_valid, 0);
    check("oob_col_ready", req_ready, 1);
    check("oob_col_busy", busy, 0);
    @(negedge clk);
    check("oob_col_done_clear", done, 0);
    check("oob_col_no_px_late", px_valid, 0);
    send_req(8'h41, 7'd3, 6'd60);
    check("oob_row_done", done, 1);
    check("oob_row_err", done_err, 1);
    check("oob_row_no_px", px_valid, 0);
    @(negedge clk);
    check("oob_row_err_clear", done_err, 0);

    // Random sink stalls: same pixel stream as the unstalled case.
    send_req(8'h41, 7'd10, 6'd20);
    collect(8'h41, 7'd10, 6'd20, 1'b1);
    @(negedge clk);

    // Reset asserted while line 3 is shifting out.
    send_req(8'h41, 7'd1, 6'd2);
    repeat (30) @(negedge clk);
    check("pre_reset_shifting", px_valid, 1);
    check("pre_reset_line3_y", px_y, 2 * 8 + 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    check_reset_outputs("midreset_held");
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_no_done", done, 0);
      check("post_reset_idle", busy, 0);
    end

    // Code above 8'h7F is replaced by '?'.
    send_req(8'hC8, 7'd5, 6'd7);
    collect(8'h3F, 7'd5, 6'd7, 1'b0);
    @(negedge clk);

    // Back-to-back: second handshake lands in the done cycle of the first.
    send_req(8'h41, 7'd2, 6'd4);
    req_valid = 1'b1;
    req_ascii = 8'h7F;
    req_col   = 7'd3;
    req_row   = 6'd4;
    collect(8'h41, 7'd2, 6'd4, 1'b0);
    check("b2b_ready_in_done", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_fetch_next", busy, 1);
    collect(8'h7F, 7'd3, 6'd4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
